// File: rtl/rca_slice_sequencer_if.sv
// Start/busy/done handshake bundle for rca_slice_sequencer.
// The V overflow flag exists only when OVF_FLAG_EN is defined.
interface rca_slice_sequencer_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] A2;
  logic             in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C;
`ifdef OVF_FLAG_EN
  logic             V;

  modport master (output start, A1, A2, in, input busy, done, S, C, V);
  modport slave  (input start, A1, A2, in, output busy, done, S, C, V);
`else
  modport master (output start, A1, A2, in, input busy, done, S, C);
  modport slave  (input start, A1, A2, in, output busy, done, S, C);
`endif
endinterface

// File: rtl/rca_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder: one SLICE-bit ripple-carry slice per clock.
// Optional signed-overflow output V is enabled by defining OVF_FLAG_EN.
module rca_slice_sequencer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rca_slice_sequencer_if.slave bus
);
  localparam int unsigned NSLICES = WIDTH / SLICE;
  localparam int unsigned CNTW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam int unsigned OFFW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a1_q;
  logic [WIDTH-1:0] a2_q;
  logic [WIDTH-1:0] psum_q;
  logic             carry_q;
  logic [CNTW-1:0]  cnt_q;

  logic [OFFW-1:0]  off_c;
  logic [SLICE-1:0] a_slice_c;
  logic [SLICE-1:0] b_slice_c;
  logic [SLICE:0]   slice_sum_c;
  logic [WIDTH-1:0] psum_nxt_c;
  logic             last_c;
`ifdef OVF_FLAG_EN
  logic             ovf_c;
`endif

  // The shared slice adder and the partial-sum merge for the current slice index
  always_comb begin
    off_c       = OFFW'(cnt_q) * OFFW'(SLICE);
    a_slice_c   = a1_q[off_c +: SLICE];
    b_slice_c   = a2_q[off_c +: SLICE];
    slice_sum_c = {1'b0, a_slice_c} + {1'b0, b_slice_c} + (SLICE + 1)'(carry_q);
    psum_nxt_c  = psum_q;
    psum_nxt_c[off_c +: SLICE] = slice_sum_c[SLICE-1:0];
    last_c      = (cnt_q == CNTW'(NSLICES - 1));
  end

`ifdef OVF_FLAG_EN
  // Carry into the MSB recovered from the MSB sum bit; only meaningful on the last slice
  always_comb begin
    ovf_c = slice_sum_c[SLICE] ^
            (a_slice_c[SLICE-1] ^ b_slice_c[SLICE-1] ^ slice_sum_c[SLICE-1]);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a1_q     <= '0;
      a2_q     <= '0;
      psum_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.S    <= '0;
      bus.C    <= 1'b0;
`ifdef OVF_FLAG_EN
      bus.V    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a1_q     <= bus.A1;
            a2_q     <= bus.A2;
            carry_q  <= bus.in;
            psum_q   <= '0;
            cnt_q    <= '0;
            bus.busy <= 1'b1;
            state_q  <= RUN;
          end else begin
            bus.busy <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RUN: begin
          psum_q  <= psum_nxt_c;
          carry_q <= slice_sum_c[SLICE];
          cnt_q   <= cnt_q + CNTW'(1);
          // Results are published only on the final slice so S/C never show partial sums
          if (last_c) begin
            bus.S    <= psum_nxt_c;
            bus.C    <= slice_sum_c[SLICE];
`ifdef OVF_FLAG_EN
            bus.V    <= ovf_c;
`endif
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state_q  <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/rca_slice_sequencer.md
Name: rca_slice_sequencer

Overview:
Multi-cycle 64-bit adder controller. It time-shares one narrow ripple-carry slice, SLICE bits wide, across the operand. It processes one slice per clock and holds the inter-slice carry in a flop. Sits in front of the arithmetic datapath wherever a full-width combinational RCA is too slow or too large, using a start/busy/done handshake.

Parameters:
WIDTH, 64, operand and sum width in bits; must be an integer multiple of SLICE.
SLICE, 16, bits added per cycle by the internal ripple-carry slice; NSLICES = WIDTH/SLICE.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when not busy
A1  input  WIDTH  operand 1; captured on the accepted start edge
A2  input  WIDTH  operand 2; captured on the accepted start edge
in  input  1  carry-in; captured on the accepted start edge
busy  output  1  high while slices are being processed
done  output  1  one-cycle pulse, S/C valid
S  output  WIDTH  registered sum
C  output  1  registered carry-out of MSB

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, S=0, C=0; slice counter=0; carry flop=0; operand registers=0. Reset asserted mid-operation aborts the add immediately. No done is produced for the aborted add.
- FSM states:
  - IDLE: busy=0. If start=1, capture A1, A2, in into internal registers, clear counter, set busy=1, go to RUN.
  - RUN: each edge adds slice k, i.e. bits [k*SLICE+SLICE-1 : k*SLICE] of the operand registers, plus the carry flop. Writes the SLICE-bit result into the partial-sum register, updates the carry flop, and increments k. When k = NSLICES-1 is processed, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. S and C are loaded from the partial sum and final carry on the edge entering DONE. If start=1 in DONE, accept the new request as in IDLE (back-to-back). Otherwise go to IDLE.
- Latency: start high at edge E0 → slices processed on E1..E_NSLICES. With the defaults, done=1 during the cycle after E4. Throughput is one add per NSLICES+1 cycles.
- Arithmetic: unsigned modulo 2^WIDTH. C is the carry out of bit WIDTH-1. Result equals the single-cycle 64-bit RCA, A1+A2+in.
- S and C hold their value until the next completed add; they are not disturbed while RUN is in progress.
- start while busy=1 is ignored. Operand inputs may change freely after the accepting edge.
- start and rst asserted together: rst wins.
- NSLICES=1 (SLICE=WIDTH) is legal: one RUN cycle.

Optional Feature:
Macro OVF_FLAG_EN.
- Defined: adds output port V (1 bit, reset 0), loaded with S together with C. V = signed two's-complement overflow = carry into MSB XOR carry out of MSB.
- Undefined: no V port and no overflow logic.

Test Plan:
- Reset, then start with A1=0, A2=0, in=0 → done pulse after E4, S=0, C=0, busy high exactly 4 cycles.
- A1=64'hFFFF_FFFF_FFFF_FFFF, A2=0, in=1 → S=0, C=1; the carry propagates through all 4 slices.
- A1=64'h0000_FFFF_FFFF_FFFF, A2=64'h1, in=0 → S=64'h0001_0000_0000_0000, C=0; the partial result must not appear on S before done.
- Start accepted; pulse start again at E2 with different operands → second start ignored, first result delivered. Then start during the DONE cycle → accepted, second result after 4 more cycles.
- Start, assert rst at E2 for one cycle → busy=0, done never pulses for the aborted add, S=0, C=0. A fresh start afterwards completes normally.
- With OVF_FLAG_EN: A1=64'h7FFF_FFFF_FFFF_FFFF, A2=64'h1, in=0 → S=64'h8000_0000_0000_0000, C=0, V=1. With A1=A2=64'h8000_0000_0000_0000 → S=0, C=1, V=1.
